// File: rtl/lzd_pkg.sv
// Shared definitions for the pipelined leading-zero detector: width derivations,
// the per-group count/flag record and the group leading-zero counter.
package lzd_pkg;

    localparam int M_DEF  = 23;
    localparam int G_DEF  = 8;
    localparam int GMAX   = 32;
    localparam int GLZC_W = 6;

    function automatic int calc_w(input int m);
        return m + 2;
    endfunction

    function automatic int calc_ng(input int w, input int g);
        return (w + g - 1) / g;
    endfunction

    function automatic int calc_sw(input int m);
        return $clog2(m + 3);
    endfunction

    localparam int W_DEF  = calc_w(M_DEF);
    localparam int NG_DEF = calc_ng(W_DEF, G_DEF);
    localparam int SW_DEF = calc_sw(M_DEF);

    typedef struct packed {
        logic              allz;
        logic [GLZC_W-1:0] lzc;
    } grp_t;

    // Leading zeros within bits[g-1:0]; returns g when that slice is all zero.
    function automatic logic [GLZC_W-1:0] group_lzc(input logic [GMAX-1:0] bits, input int g);
        logic [GLZC_W-1:0] cnt;
        logic              hit;
        cnt = GLZC_W'(g);
        hit = 1'b0;
        for (int i = GMAX - 1; i >= 0; i--) begin
            if ((i < g) && !hit && bits[i]) begin
                cnt = GLZC_W'(g - 1 - i);
                hit = 1'b1;
            end else begin
                hit = hit;
            end
        end
        return cnt;
    endfunction

endpackage

// File: rtl/lzc_group.sv
// Combinational G-bit leading-zero count plus all-zero flag for one group of
// the split count.
module lzc_group
    import lzd_pkg::*;
#(
    parameter int G = 8
) (
    input  logic [G-1:0]        bits,
    output logic [GLZC_W-1:0]   lzc,
    output logic                allz
);

    logic [GMAX-1:0] ext_s;

    // Zero-extend the group at the top so the shared counter scans only G bits.
    always_comb begin
        ext_s        = {GMAX{1'b0}};
        ext_s[G-1:0] = bits;
        lzc          = group_lzc(ext_s, G);
        allz         = ~|bits;
    end

endmodule

// File: rtl/lzd_pipe.sv
// Three-stage leading-zero detector on A-B with valid/ready flow control.
// Define LZD_PIPE_SIGN_EN to report |A-B| and the sign of the difference.
module lzd_pipe
    import lzd_pkg::*;
#(
    parameter int M           = 23,
    parameter int G           = 8,
    parameter int SHIFT_WIDTH = $clog2(M + 3)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [M+1:0]           A,
    input  logic [M+1:0]           B,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [M+1:0]           diff,
    output logic [SHIFT_WIDTH-1:0] shift_amt,
    output logic                   zero,
    output logic                   sign
);

    localparam int W  = calc_w(M);
    localparam int NG = calc_ng(W, G);
    localparam int PW = NG * G;

    logic                   en1_s, en2_s, en3_s;
    logic                   v1_r, v2_r, v3_r;
    logic [W-1:0]           d_s, d1_r, d2_r;
    logic [PW-1:0]          padded_s;
    logic [NG-1:0][GLZC_W-1:0] lzc_s, lzc2_r;
    logic [NG-1:0]          allz_s, allz2_r;
    grp_t [NG-1:0]          grp_s;
    logic [SHIFT_WIDTH-1:0] cnt_s;
    logic                   hit_s;
    logic                   zero_s;
    logic [W-1:0]           diff_r;
    logic [SHIFT_WIDTH-1:0] shift_r;
    logic                   zero_r;

    // A stage may load when it is empty or its contents move on this cycle.
    always_comb begin
        en3_s = !v3_r || out_ready;
        en2_s = !v2_r || en3_s;
        en1_s = !v1_r || en2_s;
    end

    assign in_ready  = en1_s;
    assign out_valid = v3_r;
    assign diff      = diff_r;
    assign shift_amt = shift_r;
    assign zero      = zero_r;

`ifdef LZD_PIPE_SIGN_EN
    logic lt_s, s1_r, s2_r, sign_r;

    // Magnitude of the difference so the count normalises |A-B|.
    always_comb begin
        lt_s = (A < B);
        if (lt_s) begin
            d_s = B - A;
        end else begin
            d_s = A - B;
        end
    end

    // Sign travels alongside the difference through all three stages.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_r   <= 1'b0;
            s2_r   <= 1'b0;
            sign_r <= 1'b0;
        end else begin
            if (en1_s && in_valid) begin
                s1_r <= lt_s;
            end
            if (en2_s && v1_r) begin
                s2_r <= s1_r;
            end
            if (en3_s && v2_r) begin
                sign_r <= s2_r;
            end
        end
    end

    assign sign = sign_r;
`else
    // Raw modulo-2^W difference.
    always_comb begin
        d_s = A - B;
    end

    assign sign = 1'b0;
`endif

    // Padding sits at the LSB end so it can never be counted ahead of real bits.
    always_comb begin
        padded_s            = {PW{1'b0}};
        padded_s[PW-1 -: W] = d1_r;
    end

    genvar gi;
    generate
        for (gi = 0; gi < NG; gi++) begin : g_grp
            lzc_group #(
                .G (G)
            ) u_lzc (
                .bits (padded_s[PW-1-gi*G -: G]),
                .lzc  (lzc_s[gi]),
                .allz (allz_s[gi])
            );
            assign grp_s[gi].lzc  = lzc_s[gi];
            assign grp_s[gi].allz = allz_s[gi];
        end
    endgenerate

    // First non-empty group (MSB-first) sets the count; all-zero reports W.
    always_comb begin
        cnt_s = SHIFT_WIDTH'(W);
        hit_s = 1'b0;
        for (int g = 0; g < NG; g++) begin
            if (!hit_s && !allz2_r[g]) begin
                cnt_s = SHIFT_WIDTH'(g * G) + SHIFT_WIDTH'(lzc2_r[g]);
                hit_s = 1'b1;
            end else begin
                hit_s = hit_s;
            end
        end
        zero_s = &allz2_r;
    end

    // Stage 1: operand difference.
    always_ff @(posedge clk) begin
        if (rst) begin
            v1_r <= 1'b0;
            d1_r <= {W{1'b0}};
        end else if (en1_s) begin
            v1_r <= in_valid;
            if (in_valid) begin
                d1_r <= d_s;
            end
        end
    end

    // Stage 2: per-group counts and flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            v2_r    <= 1'b0;
            d2_r    <= {W{1'b0}};
            lzc2_r  <= {(NG*GLZC_W){1'b0}};
            allz2_r <= {NG{1'b0}};
        end else if (en2_s) begin
            v2_r <= v1_r;
            if (v1_r) begin
                d2_r <= d1_r;
                for (int g = 0; g < NG; g++) begin
                    lzc2_r[g]  <= grp_s[g].lzc;
                    allz2_r[g] <= grp_s[g].allz;
                end
            end
        end
    end

    // Stage 3: output registers, held while the consumer stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            v3_r    <= 1'b0;
            diff_r  <= {W{1'b0}};
            shift_r <= {SHIFT_WIDTH{1'b0}};
            zero_r  <= 1'b0;
        end else if (en3_s) begin
            v3_r <= v2_r;
            if (v2_r) begin
                diff_r  <= d2_r;
                shift_r <= cnt_s;
                zero_r  <= zero_s;
            end
        end
    end

endmodule
